controle_elevador: RTL and testbench

Call scheduler and motion sequencer for the four-floor elevator (Térreo, 1, 2, 3). Latches hall/cab call buttons and chooses the next target with a collective up/down policy. Drives motor-up/motor-down and door outputs, and advances the 2-bit floor register one floor per timed travel interval. Sits above the floor-state datapath: it owns the current-floor value and the Erro freeze behaviour, and presents the floor as `AndarB1`/`AndarB0`.

---
 rtl/elevador_pkg.sv | 21 ++
 rtl/temporizador.sv | 30 +++
 rtl/controle_elevador.sv | 179 +++++++++++++++++
 tb/tb_controle_elevador.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elevador_pkg.sv
// Shared types and constants for the four-floor elevator controller.
package elevador_pkg;

  localparam int unsigned LARGURA_ANDAR = 2;

  typedef logic [LARGURA_ANDAR-1:0] andar_t;

  localparam andar_t TERREO = 2'd0;
  localparam andar_t ANDAR1 = 2'd1;
  localparam andar_t ANDAR2 = 2'd2;
  localparam andar_t ANDAR3 = 2'd3;

  typedef enum logic [2:0] {
    PARADO,
    SUBINDO,
    DESCENDO,
    PORTA,
    FALHA
  } estado_t;

endpackage

// File: rtl/temporizador.sv
// Loadable down-counter that saturates at zero; used for travel and door timing.
module temporizador #(
  parameter int unsigned LARGURA = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               limpa,
  input  logic               carga,
  input  logic               conta,
  input  logic [LARGURA-1:0] valor,
  output logic               zero
);

  logic [LARGURA-1:0] contagem_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      contagem_q <= '0;
    end else if (limpa) begin
      contagem_q <= '0;
    end else if (carga) begin
      contagem_q <= valor;
    end else if (conta && (contagem_q != '0)) begin
      contagem_q <= contagem_q - 1'b1;
    end
  end

  assign zero = (contagem_q == '0);

endmodule

// File: rtl/controle_elevador.sv
// Call scheduler and motion sequencer: latches calls, picks the nearest target
// (ties keep the last direction) and steps the floor one level per travel interval.
module controle_elevador
  import elevador_pkg::*;
#(
  parameter int unsigned T_VIAGEM = 4,
  parameter int unsigned T_PORTA  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Botao,
  input  logic       Erro,
  output logic       AndarB1,
  output logic       AndarB0,
  output logic       MotorSobe,
  output logic       MotorDesce,
  output logic       PortaAberta,
  output logic [3:0] Chamadas,
  output logic       Falha
);

  localparam int unsigned T_MAX     = (T_VIAGEM > T_PORTA) ? T_VIAGEM : T_PORTA;
  localparam int unsigned LARGURA_T = $clog2(T_MAX) + 1;
  // Timers load N-1 and the transition fires on the zero cycle, giving N cycles.
  localparam logic [LARGURA_T-1:0] CARGA_VIAGEM = LARGURA_T'(T_VIAGEM - 1);
  localparam logic [LARGURA_T-1:0] CARGA_PORTA  = LARGURA_T'(T_PORTA - 1);

  estado_t    estado_q, estado_d;
  andar_t     andar_q, andar_d;
  logic [3:0] chamadas_q, chamadas_d;
  logic       dir_q, dir_d;
  logic       sobe_q, desce_q, porta_q, falha_q;
  logic       zero_v, zero_p;
  logic       carga_v, carga_p, conta_v, conta_p, limpa_t;
  logic       chegada, reabre, limpa_andar;
  logic [1:0] rumo;

  // Returns {desce, sobe}; nearer distances override farther ones.
  function automatic logic [1:0] escolhe_rumo(input logic [3:0] ch, input andar_t a,
                                              input logic d);
    logic [1:0] r;
    logic       acima, abaixo;
    r = 2'b00;
    for (int k = 3; k >= 1; k--) begin
      acima  = 1'b0;
      abaixo = 1'b0;
      for (int f = 0; f < 4; f++) begin
        if (ch[f] && (f == int'(a) + k)) acima = 1'b1;
        if (ch[f] && (f == int'(a) - k)) abaixo = 1'b1;
      end
      if (acima && abaixo) r = d ? 2'b01 : 2'b10;
      else if (acima)      r = 2'b01;
      else if (abaixo)     r = 2'b10;
    end
    return r;
  endfunction

  assign rumo   = escolhe_rumo(chamadas_q, andar_q, dir_q);
  assign reabre = (estado_q == PORTA) && Botao[andar_q];

  always_comb begin
    estado_d = estado_q;
    andar_d  = andar_q;
    dir_d    = dir_q;
    chegada  = 1'b0;
    case (estado_q)
      PARADO: begin
        if (chamadas_q[andar_q]) begin
          estado_d = PORTA;
        end else if (rumo[0]) begin
          estado_d = SUBINDO;
          dir_d    = 1'b1;
        end else if (rumo[1]) begin
          estado_d = DESCENDO;
          dir_d    = 1'b0;
        end
      end
      SUBINDO: begin
        if (andar_q == ANDAR3) begin
          estado_d = PARADO;
        end else if (zero_v) begin
          andar_d = andar_q + 1'b1;
          chegada = 1'b1;
          if (chamadas_q[andar_d])                           estado_d = PORTA;
          else if ((chamadas_q & (4'b1110 << andar_d)) == 0) estado_d = PARADO;
        end
      end
      DESCENDO: begin
        if (andar_q == TERREO) begin
          estado_d = PARADO;
        end else if (zero_v) begin
          andar_d = andar_q - 1'b1;
          chegada = 1'b1;
          if (chamadas_q[andar_d])                              estado_d = PORTA;
          else if ((chamadas_q & ~(4'b1111 << andar_d)) == 0)   estado_d = PARADO;
        end
      end
      PORTA: begin
        if (!reabre && zero_p) estado_d = PARADO;
      end
      FALHA:   estado_d = PARADO;
      default: estado_d = PARADO;
    endcase
    // Fault freezes everything, including travel already in progress.
    if (Erro) begin
      estado_d = FALHA;
      andar_d  = andar_q;
      dir_d    = dir_q;
      chegada  = 1'b0;
    end
  end

  always_comb begin
    limpa_andar = (estado_q == PORTA) || (estado_d == PORTA);
    if (Erro || (estado_q == FALHA)) begin
      chamadas_d = chamadas_q;
    end else begin
      chamadas_d = (chamadas_q | Botao) & ~(limpa_andar ? (4'b0001 << andar_d) : 4'b0000);
    end
  end

  assign limpa_t = (estado_d == FALHA);
  assign conta_v = (estado_q == SUBINDO) || (estado_q == DESCENDO);
  assign carga_v = ((estado_d == SUBINDO) || (estado_d == DESCENDO)) &&
                   ((estado_q != estado_d) || chegada);
  assign conta_p = (estado_q == PORTA);
  assign carga_p = (estado_d == PORTA) && ((estado_q != PORTA) || reabre);

  temporizador #(.LARGURA(LARGURA_T)) u_viagem (
    .clk   (clk),
    .reset (reset),
    .limpa (limpa_t),
    .carga (carga_v),
    .conta (conta_v),
    .valor (CARGA_VIAGEM),
    .zero  (zero_v)
  );

  temporizador #(.LARGURA(LARGURA_T)) u_porta (
    .clk   (clk),
    .reset (reset),
    .limpa (limpa_t),
    .carga (carga_p),
    .conta (conta_p),
    .valor (CARGA_PORTA),
    .zero  (zero_p)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q   <= PARADO;
      andar_q    <= TERREO;
      chamadas_q <= 4'b0000;
      dir_q      <= 1'b1;
      sobe_q     <= 1'b0;
      desce_q    <= 1'b0;
      porta_q    <= 1'b0;
      falha_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      andar_q    <= andar_d;
      chamadas_q <= chamadas_d;
      dir_q      <= dir_d;
      sobe_q     <= (estado_d == SUBINDO);
      desce_q    <= (estado_d == DESCENDO);
      porta_q    <= (estado_d == PORTA);
      falha_q    <= (estado_d == FALHA);
    end
  end

  assign AndarB1     = andar_q[1];
  assign AndarB0     = andar_q[0];
  assign MotorSobe   = sobe_q;
  assign MotorDesce  = desce_q;
  assign PortaAberta = porta_q;
  assign Chamadas    = chamadas_q;
  assign Falha       = falha_q;

endmodule

// File: tb/tb_controle_elevador.sv
// Scoreboard bench: a remaining-cycles reference model predicts outputs each edge,
// a monitor process compares them on the falling edge.
module tb_controle_elevador;

  localparam int unsigned T_VIAGEM = 4;
  localparam int unsigned T_PORTA  = 8;
  localparam int M_PARADO = 0, M_MOVE = 1, M_PORTA = 2, M_FALHA = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Erro = 1'b0;
  logic [3:0] Botao = 4'b0000;
  logic       AndarB1, AndarB0, MotorSobe, MotorDesce, PortaAberta, Falha;
  logic [3:0] Chamadas;

  always #5 clk = ~clk;

  controle_elevador #(.T_VIAGEM(T_VIAGEM), .T_PORTA(T_PORTA)) dut (
    .clk         (clk),
    .reset       (reset),
    .Botao       (Botao),
    .Erro        (Erro),
    .AndarB1     (AndarB1),
    .AndarB0     (AndarB0),
    .MotorSobe   (MotorSobe),
    .MotorDesce  (MotorDesce),
    .PortaAberta (PortaAberta),
    .Chamadas    (Chamadas),
    .Falha       (Falha)
  );

  typedef struct packed {
    logic [1:0] andar;
    logic       sobe;
    logic       desce;
    logic       porta;
    logic       falha;
    logic [3:0] cham;
  } saida_t;

  saida_t   fila[$];
  int       n_aval = 0;
  int       n_falha = 0;
  int       m_andar, m_modo, m_resta;
  bit       m_sobe;
  bit [3:0] m_cham;

  function automatic saida_t observado();
    return {AndarB1, AndarB0, MotorSobe, MotorDesce, PortaAberta, Falha, Chamadas};
  endfunction

  function automatic saida_t esperado();
    saida_t s;
    s.andar = 2'(m_andar);
    s.sobe  = (m_modo == M_MOVE) && m_sobe;
    s.desce = (m_modo == M_MOVE) && !m_sobe;
    s.porta = (m_modo == M_PORTA);
    s.falha = (m_modo == M_FALHA);
    s.cham  = m_cham;
    return s;
  endfunction

  task automatic checar(input string nome, input saida_t obt, input saida_t req);
    n_aval++;
    if (obt !== req) begin
      n_falha++;
      $display("FAIL %s @%0t: got andar=%0d sobe=%b desce=%b porta=%b falha=%b cham=%b, expected andar=%0d sobe=%b desce=%b porta=%b falha=%b cham=%b",
               nome, $time, obt.andar, obt.sobe, obt.desce, obt.porta, obt.falha, obt.cham,
               req.andar, req.sobe, req.desce, req.porta, req.falha, req.cham);
    end
  endtask

  task automatic modelo_reset();
    m_andar = 0;
    m_modo  = M_PARADO;
    m_resta = 0;
    m_sobe  = 1'b1;
    m_cham  = 4'b0000;
  endtask

  // Nearest pending floor; equal distance resolved by the remembered direction.
  function automatic int alvo(input bit [3:0] ch);
    int melhor = -1;
    int dist_m = 99;
    int d;
    for (int f = 0; f < 4; f++) begin
      if (ch[f] && f != m_andar) begin
        d = (f > m_andar) ? f - m_andar : m_andar - f;
        if (d < dist_m) begin
          melhor = f;
          dist_m = d;
        end else if (d == dist_m && ((f > m_andar) == m_sobe)) begin
          melhor = f;
        end
      end
    end
    return melhor;
  endfunction

  function automatic bit ha_alem(input bit [3:0] ch);
    for (int f = 0; f < 4; f++)
      if (ch[f] && (m_sobe ? (f > m_andar) : (f < m_andar))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic passo(input logic [3:0] b, input logic e);
    int       modo_ant = m_modo;
    bit [3:0] ch = m_cham;
    int       t;
    if (e) begin
      m_modo  = M_FALHA;
      m_resta = 0;
      return;
    end
    if (m_modo == M_FALHA) begin
      m_modo = M_PARADO;
      return;
    end
    case (m_modo)
      M_PARADO: begin
        if (ch[m_andar]) begin
          m_modo  = M_PORTA;
          m_resta = T_PORTA;
        end else begin
          t = alvo(ch);
          if (t >= 0) begin
            m_sobe  = (t > m_andar);
            m_modo  = M_MOVE;
            m_resta = T_VIAGEM;
          end
        end
      end
      M_MOVE: begin
        m_resta--;
        if (m_resta == 0) begin
          m_andar += m_sobe ? 1 : -1;
          if (ch[m_andar]) begin
            m_modo  = M_PORTA;
            m_resta = T_PORTA;
          end else if (ha_alem(ch)) begin
            m_resta = T_VIAGEM;
          end else begin
            m_modo = M_PARADO;
          end
        end
      end
      default: begin
        if (b[m_andar]) begin
          m_resta = T_PORTA;
        end else begin
          m_resta--;
          if (m_resta == 0) m_modo = M_PARADO;
        end
      end
    endcase
    m_cham = ch | b;
    if (modo_ant == M_PORTA || m_modo == M_PORTA) m_cham[m_andar] = 1'b0;
  endtask

  task automatic ciclos(input logic [3:0] b, input logic e, input int n);
    for (int i = 0; i < n; i++) begin
      Botao = b;
      Erro  = e;
      @(posedge clk);
      #2;
    end
    Botao = 4'b0000;
    Erro  = 1'b0;
  endtask

  initial begin
    saida_t zero_s;
    logic [3:0] b;
    zero_s = '0;
    modelo_reset();
    fork
      forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
          modelo_reset();
          fila.delete();
        end else begin
          passo(Botao, Erro);
          fila.push_back(esperado());
        end
      end
      forever begin
        @(negedge clk);
        if (fila.size() > 0) checar("saidas", observado(), fila.pop_front());
      end
    join_none

    #1 reset = 1'b0;
    #1 checar("reset_inicial", observado(), zero_s);
    @(posedge clk);
    #2 reset = 1'b1;

    // Call to the top floor, then a two-floor downward sweep.
    ciclos(4'b1000, 1'b0, 1);
    ciclos(4'b0000, 1'b0, 40);
    ciclos(4'b0101, 1'b0, 1);
    ciclos(4'b0000, 1'b0, 60);
    // Park at floor 1 heading up, then an equidistant pair.
    ciclos(4'b0010, 1'b0, 1);
    ciclos(4'b0000, 1'b0, 30);
    ciclos(4'b0101, 1'b0, 1);
    ciclos(4'b0000, 1'b0, 60);
    // Door re-press at floor 2.
    ciclos(4'b0100, 1'b0, 1);
    ciclos(4'b0000, 1'b0, 16);
    ciclos(4'b0100, 1'b0, 1);
    ciclos(4'b0000, 1'b0, 20);
    // Fault in the middle of travel 1 -> 2.
    ciclos(4'b0010, 1'b0, 1);
    ciclos(4'b0000, 1'b0, 20);
    ciclos(4'b0100, 1'b0, 1);
    ciclos(4'b0000, 1'b0, 3);
    ciclos(4'b0000, 1'b1, 5);
    ciclos(4'b0000, 1'b0, 20);
    // Asynchronous reset while the door is open.
    ciclos(4'b0100, 1'b0, 1);
    ciclos(4'b0000, 1'b0, 4);
    #1 reset = 1'b0;
    #1 checar("reset_em_porta", observado(), zero_s);
    @(posedge clk);
    #2 reset = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      b = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 249) == 0) ciclos(4'b0000, 1'b1, int'($urandom_range(1, 6)));
      else                             ciclos(b, 1'b0, 1);
    end
    ciclos(4'b0000, 1'b0, 2);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_aval, n_falha);
    $finish;
  end

endmodule
